// File: rtl/dm_ctrl_if.sv
// dm_ctrl request/response bundle.
// The MEM stage drives the request side; the controller answers.
interface dm_ctrl_if #(
  parameter int IDX_W = 10
);
  logic             req;
  logic             we;
  logic [1:0]       size;
  logic             sext;
  logic [IDX_W+1:0] addr;
  logic [31:0]      wdata;
  logic             busy;
  logic             ready;
  logic [31:0]      rdata;
  logic             fault;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  busy, ready, rdata, fault
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output busy, ready, rdata, fault
  );
endinterface

// File: rtl/dm_ctrl.sv
// Word-organised data RAM with byte/half/word access,
// wait states, load extension and alignment faults.
module dm_ctrl #(
  parameter int IDX_W       = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic     Clk,
  input  logic     Rst_n,
  dm_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic             r_busy;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_sext;
  logic [IDX_W+1:0] r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_fault;

  logic [31:0] r_mem [1<<IDX_W];

  logic             w_accept;
  logic             w_do;
  logic             w_done;
  logic             w_fault;
  logic [3:0]       w_be;
  logic [31:0]      w_wlane;
  logic [31:0]      w_word;
  logic [31:0]      w_shift;
  logic [31:0]      w_load;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             w_is_b;
  logic             w_is_h;
  logic             w_is_w;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_do     = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_accept = 1'b1;
          w_next   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_do   = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_idx   = r_addr[IDX_W+1:2];
  assign w_lane  = r_addr[1:0];
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};
  assign w_is_b  = (r_size == 2'b00);
  assign w_is_h  = (r_size == 2'b01);
  assign w_is_w  = (r_size == 2'b10);

  // Reserved size matches no arm and keeps the fault default.
  always_comb begin
    w_fault = 1'b1;
    w_be    = 4'b0000;
    w_wlane = r_wdata;
    w_load  = 32'd0;
    unique case (1'b1)
      w_is_b: begin
        w_fault = 1'b0;
        w_be    = 4'b0001 << w_lane;
        w_wlane = {4{r_wdata[7:0]}};
        w_load  = {{24{r_sext & w_shift[7]}},
                   w_shift[7:0]};
      end
      w_is_h: begin
        w_fault = w_lane[0];
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{r_wdata[15:0]}};
        w_load  = {{16{r_sext & w_shift[15]}},
                   w_shift[15:0]};
      end
      w_is_w: begin
        w_fault = |w_lane;
        w_be    = 4'b1111;
        w_wlane = r_wdata;
        w_load  = w_word;
      end
      default: begin
        w_fault = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.we;
        r_size  <= bus.size;
        r_sext  <= bus.sext;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_cnt   <= 4'(WAIT_CYCLES);
        r_busy  <= 1'b1;
      end else if (r_state == S_ACCESS &&
                   r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        r_busy <= 1'b0;
      end
      if (w_do) begin
        r_fault <= w_fault;
        r_rdata <= (w_fault | r_we) ? 32'd0 : w_load;
      end
    end
  end

  // Contents survive reset; reset only stops the FSM.
  always_ff @(posedge Clk) begin
    if (w_do && !w_fault && r_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
        end
      end
    end
  end

  assign bus.busy  = r_busy;
  assign bus.ready = (r_state == S_RESP);
  assign bus.rdata = r_rdata;
  assign bus.fault = r_fault;

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: directed table, wait-state, reset,
// back-to-back and randomized checks against a byte model.
module tb_dm_ctrl;

  logic Clk = 1'b0;
  logic Rst0_n;
  logic Rst3_n;

  always #5 Clk = ~Clk;

  dm_ctrl_if #(.IDX_W(10)) b0 ();
  dm_ctrl_if #(.IDX_W(10)) b3 ();

  dm_ctrl #(.IDX_W(10), .WAIT_CYCLES(0)) u0 (
    .Clk   (Clk),
    .Rst_n (Rst0_n),
    .bus   (b0)
  );

  dm_ctrl #(.IDX_W(10), .WAIT_CYCLES(3)) u3 (
    .Clk   (Clk),
    .Rst_n (Rst3_n),
    .bus   (b3)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit        we;
    bit [1:0]  sz;
    bit        sx;
    bit [11:0] a;
    bit [31:0] wd;
    bit [31:0] er;
    bit        ef;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] mb [int];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit r,
                       input bit we, input bit [1:0] sz,
                       input bit sx, input bit [11:0] a,
                       input bit [31:0] wd);
    if (sel) begin
      b3.req = r; b3.we = we; b3.size = sz;
      b3.sext = sx; b3.addr = a; b3.wdata = wd;
    end else begin
      b0.req = r; b0.we = we; b0.size = sz;
      b0.sext = sx; b0.addr = a; b0.wdata = wd;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b3.ready : b0.ready;
  endfunction

  function automatic logic bsy(input bit sel);
    return sel ? b3.busy : b0.busy;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One full transaction from IDLE back to IDLE.
  task automatic access(input bit sel, input bit we,
                        input bit [1:0] sz, input bit sx,
                        input bit [11:0] a,
                        input bit [31:0] wd,
                        output logic [31:0] rd,
                        output logic f,
                        output int lat);
    drive(sel, 1'b1, we, sz, sx, a, wd);
    tick();
    drive(sel, 1'b0, we, sz, sx, a, wd);
    lat = 0;
    while (!rdy(sel) && lat < 40) begin
      tick();
      lat++;
    end
    if (!rdy(sel)) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end
    rd = sel ? b3.rdata : b0.rdata;
    f  = sel ? b3.fault : b0.fault;
    tick();
    chk("ready_one_pulse",
        {30'd0, rdy(sel), bsy(sel)}, 32'd0);
  endtask

  // Byte-addressed reference: faults by divisibility,
  // loads assembled lane by lane then extended.
  task automatic model(input bit we, input bit [1:0] sz,
                       input bit sx, input bit [11:0] a,
                       input bit [31:0] wd,
                       output logic [31:0] rd,
                       output logic f);
    int n;
    logic [31:0] v;
    logic [31:0] mask;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    f  = (sz == 2'd3) || ((int'(a) % n) != 0);
    rd = 32'd0;
    if (!f) begin
      if (we) begin
        for (int i = 0; i < n; i++)
          mb[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++)
          v = v | (32'(mb[int'(a) + i]) << (8 * i));
        mask = (n == 4) ? 32'hFFFF_FFFF
                        : ((32'd1 << (8 * n)) - 32'd1);
        if (sx && v[8*n-1]) rd = v | ~mask;
        else                rd = v;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] erd;
    logic        f;
    logic        ef;
    int          lat;
    int          nrdy;
    int          nbsy;
    int          last;
    int          k;
    logic [31:0] vals [4];

    Rst0_n = 1'b0;
    Rst3_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 32'd0);
    #2;
    chk("rst0_outs", {29'd0, b0.busy, b0.ready, b0.fault},
        32'd0);
    chk("rst0_rdata", b0.rdata, 32'd0);
    chk("rst3_outs", {29'd0, b3.busy, b3.ready, b3.fault},
        32'd0);
    chk("rst3_rdata", b3.rdata, 32'd0);
    tick();
    tick();
    Rst0_n = 1'b1;
    Rst3_n = 1'b1;
    tick();

    tbl.push_back('{1, 2'd2, 0, 12'h010, 32'hDEADBEEF, 32'h0, 0});
    tbl.push_back('{0, 2'd2, 0, 12'h010, 32'h0, 32'hDEADBEEF, 0});
    tbl.push_back('{1, 2'd2, 0, 12'h010, 32'h11223344, 32'h0, 0});
    tbl.push_back('{1, 2'd0, 0, 12'h011, 32'h0000005A, 32'h0, 0});
    tbl.push_back('{0, 2'd2, 0, 12'h010, 32'h0, 32'h11225A44, 0});
    tbl.push_back('{0, 2'd0, 1, 12'h013, 32'h0, 32'h00000011, 0});
    tbl.push_back('{1, 2'd1, 0, 12'h012, 32'h00008001, 32'h0, 0});
    tbl.push_back('{0, 2'd1, 1, 12'h012, 32'h0, 32'hFFFF8001, 0});
    tbl.push_back('{0, 2'd1, 0, 12'h012, 32'h0, 32'h00008001, 0});
    tbl.push_back('{0, 2'd2, 0, 12'h010, 32'h0, 32'h80015A44, 0});
    tbl.push_back('{1, 2'd2, 0, 12'h020, 32'hCAFEF00D, 32'h0, 0});
    tbl.push_back('{1, 2'd1, 0, 12'h021, 32'h0000BEEF, 32'h0, 1});
    tbl.push_back('{0, 2'd2, 0, 12'h022, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 2'd2, 0, 12'h020, 32'h0, 32'hCAFEF00D, 0});
    tbl.push_back('{0, 2'd3, 0, 12'h020, 32'h0, 32'h0, 1});
    tbl.push_back('{0, 2'd0, 1, 12'h020, 32'h0, 32'h0000000D, 0});
    tbl.push_back('{0, 2'd0, 1, 12'h023, 32'h0, 32'hFFFFFFCA, 0});
    tbl.push_back('{0, 2'd0, 0, 12'h023, 32'h0, 32'h000000CA, 0});
    tbl.push_back('{0, 2'd1, 1, 12'h020, 32'h0, 32'hFFFFF00D, 0});
    tbl.push_back('{1, 2'd1, 0, 12'h022, 32'h12345678, 32'h0, 0});
    tbl.push_back('{0, 2'd2, 0, 12'h020, 32'h0, 32'h5678F00D, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      access(1'b0, tbl[i].we, tbl[i].sz, tbl[i].sx,
             tbl[i].a, tbl[i].wd, rd, f, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].er);
      chk($sformatf("tbl%0d_fault", i), {31'd0, f},
          {31'd0, tbl[i].ef});
      chk($sformatf("tbl%0d_lat", i), lat, 1);
    end

    // Wait states: busy window, single ready, ignored req.
    drive(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 12'h100, 32'hA5A5_0F0F);
    tick();
    nrdy = 0;
    nbsy = 0;
    for (int i = 0; i < 12; i++) begin
      if (b3.ready) begin
        nrdy++;
        chk("ws_ready_cycle", i, 4);
      end
      if (b3.busy) nbsy++;
      b3.req = (i == 1);
      tick();
    end
    b3.req = 1'b0;
    chk("ws_ready_count", nrdy, 1);
    chk("ws_busy_cycles", nbsy, 5);
    access(1'b1, 1'b0, 2'd2, 1'b0, 12'h100, 32'd0,
           rd, f, lat);
    chk("ws_load", rd, 32'hA5A5_0F0F);
    chk("ws_lat", lat, 4);

    // Reset in the middle of a store.
    access(1'b1, 1'b1, 2'd2, 1'b0, 12'h104, 32'h0123_4567,
           rd, f, lat);
    access(1'b1, 1'b0, 2'd2, 1'b0, 12'h104, 32'd0,
           rd, f, lat);
    chk("rst_pre_load", rd, 32'h0123_4567);
    drive(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 12'h104, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 12'h104, 32'hFFFF_FFFF);
    tick();
    Rst3_n = 1'b0;
    #1;
    chk("rst_mid_outs",
        {29'd0, b3.busy, b3.ready, b3.fault}, 32'd0);
    chk("rst_mid_rdata", b3.rdata, 32'd0);
    nrdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b3.ready) nrdy++;
    end
    Rst3_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b3.ready) nrdy++;
    end
    chk("rst_no_ready", nrdy, 0);
    access(1'b1, 1'b0, 2'd2, 1'b0, 12'h104, 32'd0,
           rd, f, lat);
    chk("rst_mem_kept", rd, 32'h0123_4567);

    // req held high, alternating store/load at top word.
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    k = 0;
    last = -1;
    drive(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 12'hFFC, vals[0]);
    for (int c = 0; c < 120 && k < 8; c++) begin
      tick();
      if (b3.ready) begin
        if (k > 0) chk("b2b_interval", c - last, 6);
        chk("b2b_fault", {31'd0, b3.fault}, 32'd0);
        if (k % 2 == 1)
          chk("b2b_load", b3.rdata, vals[k/2]);
        last = c;
        k++;
        if (k < 8)
          drive(1'b1, 1'b1, (k % 2 == 0), 2'd2, 1'b0,
                12'hFFC, vals[k/2]);
        else
          b3.req = 1'b0;
      end
    end
    b3.req = 1'b0;
    chk("b2b_count", k, 8);
    tick();

    // Randomized traffic on words 0x40..0x4F of u0.
    for (int w = 0; w < 16; w++) begin
      rd = $urandom;
      model(1'b1, 2'd2, 1'b0, 12'(12'h100 + 4 * w), rd,
            erd, ef);
      access(1'b0, 1'b1, 2'd2, 1'b0, 12'(12'h100 + 4 * w),
             rd, erd, f, lat);
    end
    for (int i = 0; i < 200; i++) begin
      bit        we;
      bit [1:0]  sz;
      bit        sx;
      bit [11:0] a;
      bit [31:0] wd;
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = 12'(12'h100 + $urandom_range(0, 63));
      wd = $urandom;
      model(we, sz, sx, a, wd, erd, ef);
      access(1'b0, we, sz, sx, a, wd, rd, f, lat);
      tests++;
      if (rd !== erd || f !== ef || lat != 1) begin
        fails++;
        $display("FAIL rand%0d a=%h sz=%0d we=%0d: got %h/%0d/%0d expected %h/%0d/1",
                 i, a, sz, we, rd, f, lat, erd, ef);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
